// File: rtl/n_bit_serial_twos_to_signmag_pkg.sv
// alu_pkg
//   Shared definitions for the bit-serial two's-complement to sign-magnitude
//   decoder: FSM state encodings and a constant-foldable clog2 helper used to
//   size the step counter.
//   No ports.
package alu_pkg;

  // FSM state encodings, kept as plain localparams for legacy tools
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest r such that 2**r >= value
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/n_bit_serial_twos_to_signmag_if.sv
// n_bit_serial_twos_to_signmag_if
//   Handshake bundle for the serial two's-complement to sign-magnitude decoder.
//   Ports (signals):
//     in_valid/in_ready/in_data     operand input channel (valid/ready)
//     out_valid/out_ready/out_data  {sign, magnitude} result channel
//     out_ovf                       result saturated (input was -2^(WIDTH-1))
//     busy                          decoder is not idle
//   Modports: master = producer/consumer side, slave = decoder side.
interface n_bit_serial_twos_to_signmag_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

endinterface

// File: rtl/n_bit_serial_twos_to_signmag_cell.sv
// twos_serial_cell
//   One-bit datapath slice of the serial negator. Copies incoming bits until
//   the first 1 has been seen, then inverts the rest (only for negative words).
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     b           current input bit (LSB first)
//     sign        word is negative
//     en          a conversion step happens this cycle
//     clr         start of a new word; forget any previously seen 1
//     ob          resolved magnitude bit for this step
module twos_serial_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic b,
  input  logic sign,
  input  logic en,
  input  logic clr,
  output logic ob
);

  logic seen_one;

  // Remembers whether a 1 has already passed through on a negative word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one <= 1'b0;
    end else if (clr) begin
      seen_one <= 1'b0;
    end else if (en && sign && b) begin
      seen_one <= 1'b1;
    end
  end

  assign ob = sign ? (b ^ seen_one) : b;

endmodule

// File: rtl/n_bit_serial_twos_to_signmag.sv
// n_bit_serial_twos_to_signmag
//   Bit-serial decoder from two's-complement to sign-magnitude. A WIDTH-bit
//   signed word is accepted over valid/ready, its magnitude is resolved LSB
//   first one bit per cycle, and {sign, magnitude} is presented over
//   valid/ready. The most negative input saturates to -(2^(WIDTH-1)-1) and
//   raises out_ovf.
//   Parameters: WIDTH (>= 2) word width including the sign bit.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of n_bit_serial_twos_to_signmag_if (in_*, out_*, busy)
//   Configuration macro: TWOS_SM_FASTPOS_EN - when defined, non-negative words
//   bypass the serial conversion and reach DONE on the accepting edge.
module n_bit_serial_twos_to_signmag
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                                 clk,
  input logic                                 rst_n,
  n_bit_serial_twos_to_signmag_if.slave       bus
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

  logic [1:0]       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-2:0] shift_q;
  logic             sign_q;
  logic [WIDTH-2:0] mag_q;
  logic [WIDTH-2:0] mag_next;
  logic [WIDTH-1:0] out_data_q;
  logic             out_ovf_q;
  logic             accept;
  logic             conv_step;
  logic             cell_ob;
  logic             ovf_next;

  assign accept    = bus.in_valid && (state_q == ST_IDLE);
  assign conv_step = (state_q == ST_CONV);

  twos_serial_cell u_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (shift_q[0]),
    .sign  (sign_q),
    .en    (conv_step),
    .clr   (accept),
    .ob    (cell_ob)
  );

  // Output assembly register shifts right with the new bit entering at the
  // top, so the first (LSB) bit lands at position 0 after WIDTH-1 steps
  always_comb begin
    mag_next = '0;
    for (int i = 0; i < WIDTH - 2; i++) begin
      mag_next[i] = mag_q[i+1];
    end
    mag_next[WIDTH-2] = cell_ob;
  end

  // A negative word whose magnitude bits resolve to zero can only be 100..0
  assign ovf_next = sign_q && (mag_next == '0);

  // Control FSM plus the input/output shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            shift_q <= bus.in_data[WIDTH-2:0];
            sign_q  <= bus.in_data[WIDTH-1];
            cnt_q   <= '0;
            mag_q   <= '0;
`ifdef TWOS_SM_FASTPOS_EN
            if (!bus.in_data[WIDTH-1]) begin
              out_data_q <= bus.in_data;
              out_ovf_q  <= 1'b0;
              state_q    <= ST_DONE;
            end else begin
              state_q <= ST_CONV;
            end
`else
            state_q <= ST_CONV;
`endif
          end
        end
        ST_CONV: begin
          shift_q <= shift_q >> 1;
          mag_q   <= mag_next;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            out_ovf_q  <= ovf_next;
            out_data_q <= ovf_next ? '1 : {sign_q, mag_next};
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_n_bit_serial_twos_to_signmag.sv
// tb_n_bit_serial_twos_to_signmag
//   Self-checking bench: directed WIDTH=8 scenarios followed by a randomized
//   WIDTH=32 stream scored against an arithmetic reference model.
module tb_n_bit_serial_twos_to_signmag;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  n_bit_serial_twos_to_signmag_if #(.WIDTH(8))  bus8 ();
  n_bit_serial_twos_to_signmag_if #(.WIDTH(32)) bus32 ();

  n_bit_serial_twos_to_signmag #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  n_bit_serial_twos_to_signmag #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: interpret the low w bits as a signed integer, take its
  // absolute value, and saturate when it does not fit in w-1 bits
  function automatic void refModel(input int w, input logic [31:0] x,
                                   output logic [31:0] d, output logic o);
    longint full, half, v, m;
    full = longint'(1) << w;
    half = full >> 1;
    v = longint'(x) & (full - 1);
    if (v >= half) v = v - full;
    m = (v < 0) ? -v : v;
    o = (m >= half);
    if (o) d = 32'(full - 1);
    else   d = 32'(((v < 0) ? half : longint'(0)) | m);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one word to dut8 and returns the number of edges after the
  // accepting edge until out_valid is seen
  task automatic sendWord8(input logic [7:0] x, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    bus8.in_data  = x;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic int expLat8(input logic [7:0] x);
`ifdef TWOS_SM_FASTPOS_EN
    if (!x[7]) return 0;
`endif
    return 7;
  endfunction

  // Full directed transaction on dut8: send, check latency/result, drain
  task automatic applyStimulus(input string tag, input logic [7:0] x,
                               input logic [7:0] exp_data, input logic exp_ovf);
    int lat;
    sendWord8(x, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat8(x)));
    checkOutput({tag, " data"}, 32'(bus8.out_data), 32'(exp_data));
    checkOutput({tag, " ovf"}, 32'(bus8.out_ovf), 32'(exp_ovf));
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    checkOutput({tag, " drained valid"}, 32'(bus8.out_valid), 32'd0);
    checkOutput({tag, " back to idle"}, 32'(bus8.in_ready), 32'd1);
  endtask

  logic [31:0] exp_d;
  logic        exp_o;
  logic [7:0]  rnd8;
  int          lat;
  bit          saw_valid;

  logic [31:0] word32;
  bit          pending;
  int          received;
  int          cycles;
  logic [31:0] q_data[$];
  logic        q_ovf[$];
  logic [31:0] pop_d;
  logic        pop_o;
  int          sel;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.in_data    = '0;
    bus8.out_ready  = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.in_data   = '0;
    bus32.out_ready = 1'b0;

    // Reset state
    #12;
    checkOutput("reset out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(bus8.out_data), 32'd0);
    checkOutput("reset out_ovf", 32'(bus8.out_ovf), 32'd0);
    checkOutput("reset busy", 32'(bus8.busy), 32'd0);
    checkOutput("reset in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("reset in_ready32", 32'(bus32.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Negative, positive, zero and most-negative words
    applyStimulus("neg FA", 8'hFA, 8'h86, 1'b0);
    applyStimulus("neg FF", 8'hFF, 8'h81, 1'b0);
    applyStimulus("pos 05", 8'h05, 8'h05, 1'b0);
    applyStimulus("zero 00", 8'h00, 8'h00, 1'b0);
    applyStimulus("ovf 80", 8'h80, 8'hFF, 1'b1);
    applyStimulus("max 7F", 8'h7F, 8'h7F, 1'b0);
    applyStimulus("neg 81", 8'h81, 8'hFF, 1'b0);

    // A few random 8-bit words against the model
    for (int i = 0; i < 6; i++) begin
      rnd8 = 8'($urandom);
      refModel(8, 32'(rnd8), exp_d, exp_o);
      applyStimulus("rand8", rnd8, exp_d[7:0], exp_o);
    end

    // Backpressure in DONE, with an ignored in_valid meanwhile
    sendWord8(8'hC3, lat);
    checkOutput("bp latency", 32'(lat), 32'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.in_data  = 8'h11;
      checkOutput("bp data stable", 32'(bus8.out_data), 32'hBD);
      checkOutput("bp in_ready", 32'(bus8.in_ready), 32'd0);
      checkOutput("bp busy", 32'(bus8.busy), 32'd1);
    end
    @(negedge clk);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp handshake valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("bp handshake busy", 32'(bus8.busy), 32'd0);
    saw_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) saw_valid = 1'b1;
    end
    bus8.out_ready = 1'b0;
    checkOutput("bp single handshake", 32'(saw_valid), 32'd0);

    // Reset in the middle of a conversion
    @(negedge clk);
    bus8.in_data  = 8'hFA;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("midreset busy", 32'(bus8.busy), 32'd0);
    checkOutput("midreset in_ready", 32'(bus8.in_ready), 32'd1);
    checkOutput("midreset out_data", 32'(bus8.out_data), 32'd0);
    checkOutput("midreset out_ovf", 32'(bus8.out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) saw_valid = 1'b1;
    end
    checkOutput("midreset no output", 32'(saw_valid), 32'd0);
    applyStimulus("after reset 9C", 8'h9C, 8'hE4, 1'b0);

    // Randomized 32-bit stream with random in_valid / out_ready
    pending  = 1'b0;
    received = 0;
    cycles   = 0;
    word32   = '0;
    while (received < 40 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!pending && $urandom_range(0, 3) != 0) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      word32 = 32'h8000_0000;
        else if (sel == 1) word32 = 32'h0000_0000;
        else if (sel == 2) word32 = 32'hFFFF_FFFF;
        else               word32 = $urandom;
        pending = 1'b1;
      end
      bus32.in_valid  = pending;
      bus32.in_data   = word32;
      bus32.out_ready = 1'($urandom_range(0, 1));
      if (bus32.out_valid && bus32.out_ready) begin
        if (q_data.size() == 0) begin
          checkOutput("stream unexpected output", 32'd1, 32'd0);
        end else begin
          pop_d = q_data.pop_front();
          pop_o = q_ovf.pop_front();
          checkOutput("stream data", bus32.out_data, pop_d);
          checkOutput("stream ovf", 32'(bus32.out_ovf), 32'(pop_o));
        end
        received++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        refModel(32, word32, exp_d, exp_o);
        q_data.push_back(exp_d);
        q_ovf.push_back(exp_o);
        pending = 1'b0;
      end
    end
    @(negedge clk);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b0;
    checkOutput("stream completed", 32'(received), 32'd40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
